// File: rtl/control_sequencer_if.sv
// Control bundle between the SLC-3 microsequencer and the datapath/top level.
// The master drives every load, gate, mux select and memory strobe; the slave
// returns the instruction fields and branch enable the sequencer branches on.
interface control_sequencer_if;
   // Datapath feedback
   logic [3:0] opcode;
   logic       ir_5;
   logic       ir_11;
   logic       ben;
   // Register loads
   logic       ld_mar;
   logic       ld_mdr;
   logic       ld_ir;
   logic       ld_ben;
   logic       ld_cc;
   logic       ld_reg;
   logic       ld_pc;
   logic       ld_led;
   // Bus drivers
   logic       gate_pc;
   logic       gate_mdr;
   logic       gate_alu;
   logic       gate_marmux;
   // Mux selects
   logic [1:0] pcmux;
   logic [1:0] addr2mux;
   logic       addr1mux;
   logic [1:0] aluk;
   logic       sr2mux;
   logic       sr1mux;
   logic       drmux;
   logic       marmux;
   logic       mio_en;
   // Active-low SRAM strobes
   logic       mem_oe;
   logic       mem_we;
   logic [4:0] state_dbg;

   modport master (
      input  opcode, ir_5, ir_11, ben,
      output ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
      output gate_pc, gate_mdr, gate_alu, gate_marmux,
      output pcmux, addr2mux, addr1mux, aluk, sr2mux, sr1mux, drmux, marmux, mio_en,
      output mem_oe, mem_we, state_dbg
   );

   modport slave (
      output opcode, ir_5, ir_11, ben,
      input  ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
      input  gate_pc, gate_mdr, gate_alu, gate_marmux,
      input  pcmux, addr2mux, addr1mux, aluk, sr2mux, sr1mux, drmux, marmux, mio_en,
      input  mem_oe, mem_we, state_dbg
   );
endinterface

// File: rtl/control_sequencer.sv
// SLC-3 microsequencer: fetch/decode/execute FSM with a programmable memory
// wait counter. All control outputs are registered and reflect the current state.
module control_sequencer #(
   parameter int unsigned MEM_CYCLES = 3
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_run,
   input  logic i_continue,
   control_sequencer_if.master io_dp
);

   localparam int unsigned CntW = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;

   typedef enum logic [4:0] {
      StS00    = 5'd0,
      StS01    = 5'd1,
      StS04    = 5'd4,
      StS05    = 5'd5,
      StS06    = 5'd6,
      StS07    = 5'd7,
      StS09    = 5'd9,
      StS32    = 5'd10,
      StS33    = 5'd11,
      StS12    = 5'd12,
      StS35    = 5'd13,
      StP1     = 5'd14,
      StP2     = 5'd15,
      StS16    = 5'd16,
      StHalted = 5'd17,
      StS18    = 5'd18,
      StS21    = 5'd21,
      StS22    = 5'd22,
      StS23    = 5'd23,
      StS25    = 5'd25,
      StS27    = 5'd27
   } state_t;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_ben;
      logic       ld_cc;
      logic       ld_reg;
      logic       ld_pc;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic [1:0] addr2mux;
      logic       addr1mux;
      logic [1:0] aluk;
      logic       sr2mux;
      logic       sr1mux;
      logic       drmux;
      logic       marmux;
      logic       mio_en;
      logic       mem_oe;
      logic       mem_we;
   } ctrl_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CntW-1:0]   r_wait;
   logic [CntW-1:0]   w_wait_next;
   logic              w_mem_state;
   logic              w_wait_done;
   ctrl_t             r_ctrl;
   logic              r_ld_led;

   // Control word for a state; IR bits are stable from S35 onward.
   function automatic ctrl_t f_decode(state_t s, logic ir5, logic ir11);
      ctrl_t c;
      c        = '0;
      c.mem_oe = 1'b1;
      c.mem_we = 1'b1;
      case (s)
         StS18: begin
            c.gate_pc = 1'b1;
            c.ld_mar  = 1'b1;
            c.ld_pc   = 1'b1;
         end
         StS33, StS25: begin
            c.mem_oe = 1'b0;
            c.mio_en = 1'b1;
            c.ld_mdr = 1'b1;
         end
         StS35: begin
            c.gate_mdr = 1'b1;
            c.ld_ir    = 1'b1;
         end
         StS32: c.ld_ben = 1'b1;
         StS01, StS05: begin
            c.sr2mux   = ir5;
            c.aluk     = (s == StS05) ? 2'b01 : 2'b00;
            c.gate_alu = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         StS09: begin
            c.aluk     = 2'b10;
            c.gate_alu = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         StS22: begin
            c.addr2mux = 2'b10;
            c.pcmux    = 2'b10;
            c.ld_pc    = 1'b1;
         end
         StS12: begin
            c.aluk     = 2'b11;
            c.gate_alu = 1'b1;
            c.pcmux    = 2'b01;
            c.ld_pc    = 1'b1;
         end
         StS04: begin
            c.gate_pc = 1'b1;
            c.drmux   = 1'b1;
            c.ld_reg  = 1'b1;
         end
         StS21: begin
            c.addr1mux = ~ir11;
            c.addr2mux = ir11 ? 2'b11 : 2'b00;
            c.pcmux    = 2'b10;
            c.ld_pc    = 1'b1;
         end
         StS06, StS07: begin
            c.addr1mux    = 1'b1;
            c.addr2mux    = 2'b01;
            c.marmux      = 1'b1;
            c.gate_marmux = 1'b1;
            c.ld_mar      = 1'b1;
         end
         StS27: begin
            c.gate_mdr = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         StS23: begin
            c.sr1mux   = 1'b1;
            c.aluk     = 2'b11;
            c.gate_alu = 1'b1;
            c.ld_mdr   = 1'b1;
         end
         StS16: c.mem_we = 1'b0;
         default: ;
      endcase
      return c;
   endfunction

   assign w_mem_state = (r_state == StS33) || (r_state == StS25) || (r_state == StS16);
   assign w_wait_done = (r_wait == CntW'(MEM_CYCLES - 1));

   // Next-state selection and wait-counter advance.
   always_comb begin
      w_state_next = r_state;
      w_wait_next  = (w_mem_state && !w_wait_done) ? r_wait + CntW'(1) : '0;
      case (r_state)
         StHalted: if (i_run) w_state_next = StS18;
         StS18:    w_state_next = StS33;
         StS33:    if (w_wait_done) w_state_next = StS35;
         StS35:    w_state_next = StS32;
         StS32: begin
            case (io_dp.opcode)
               4'b0001: w_state_next = StS01;
               4'b0101: w_state_next = StS05;
               4'b1001: w_state_next = StS09;
               4'b0000: w_state_next = StS00;
               4'b1100: w_state_next = StS12;
               4'b0100: w_state_next = StS04;
               4'b0110: w_state_next = StS06;
               4'b0111: w_state_next = StS07;
               4'b1101: w_state_next = StP1;
               default: w_state_next = StS18;
            endcase
         end
         StS00:    w_state_next = io_dp.ben ? StS22 : StS18;
         StS04:    w_state_next = StS21;
         StS06:    w_state_next = StS25;
         StS25:    if (w_wait_done) w_state_next = StS27;
         StS07:    w_state_next = StS23;
         StS23:    w_state_next = StS16;
         StS16:    if (w_wait_done) w_state_next = StS18;
         StP1:     if (i_continue) w_state_next = StP2;
         StP2:     if (!i_continue) w_state_next = StS18;
         StS01, StS05, StS09, StS12, StS21, StS22, StS27: w_state_next = StS18;
         default:  w_state_next = StHalted;
      endcase
   end

   // State, wait counter and registered control word; reset overrides everything.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= StHalted;
         r_wait   <= '0;
         r_ctrl   <= f_decode(StHalted, 1'b0, 1'b0);
         r_ld_led <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_wait   <= w_wait_next;
         r_ctrl   <= f_decode(w_state_next, io_dp.ir_5, io_dp.ir_11);
         // Pulse only on the cycle P1 is entered.
         r_ld_led <= (w_state_next == StP1) && (r_state != StP1);
      end
   end

   assign io_dp.ld_mar      = r_ctrl.ld_mar;
   assign io_dp.ld_mdr      = r_ctrl.ld_mdr;
   assign io_dp.ld_ir       = r_ctrl.ld_ir;
   assign io_dp.ld_ben      = r_ctrl.ld_ben;
   assign io_dp.ld_cc       = r_ctrl.ld_cc;
   assign io_dp.ld_reg      = r_ctrl.ld_reg;
   assign io_dp.ld_pc       = r_ctrl.ld_pc;
   assign io_dp.ld_led      = r_ld_led;
   assign io_dp.gate_pc     = r_ctrl.gate_pc;
   assign io_dp.gate_mdr    = r_ctrl.gate_mdr;
   assign io_dp.gate_alu    = r_ctrl.gate_alu;
   assign io_dp.gate_marmux = r_ctrl.gate_marmux;
   assign io_dp.pcmux       = r_ctrl.pcmux;
   assign io_dp.addr2mux    = r_ctrl.addr2mux;
   assign io_dp.addr1mux    = r_ctrl.addr1mux;
   assign io_dp.aluk        = r_ctrl.aluk;
   assign io_dp.sr2mux      = r_ctrl.sr2mux;
   assign io_dp.sr1mux      = r_ctrl.sr1mux;
   assign io_dp.drmux       = r_ctrl.drmux;
   assign io_dp.marmux      = r_ctrl.marmux;
   assign io_dp.mio_en      = r_ctrl.mio_en;
   assign io_dp.mem_oe      = r_ctrl.mem_oe;
   assign io_dp.mem_we      = r_ctrl.mem_we;
   assign io_dp.state_dbg   = r_state;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microsequencer for the SLC-3 datapath. It runs the fetch/decode/execute state machine and drives every load, gate, mux-select and memory-strobe control the datapath consumes. It sits between the top level (Run/Continue switches, SRAM strobes) and the datapath, and receives Opcode, IR[5], IR[11] and BEN back from it. Multi-cycle memory accesses are covered by a programmable wait counter.

Parameters:
MEM_CYCLES, 3, cycles each memory read/write state is held (≥1)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high; forces Halted on next edge
Run  in  1  level; starts execution from Halted
Continue  in  1  level; releases PAUSE instruction
Opcode  in  4  IR[15:12]
IR_5  in  1  ADD/AND immediate select
IR_11  in  1  JSR vs JSRR select
BEN  in  1  branch-enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers (one-hot or all zero)
PCMUX  out  2  00 PC+1, 01 BUS, 10 address adder
ADDR2MUX  out  2  00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0])
ADDR1MUX  out  1  0 PC, 1 SR1
ALUK  out  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A
SR2MUX, SR1MUX, DRMUX, MARMUX, MIO_EN  out  1 each  mux selects (SR1MUX 1=IR[11:9]; DRMUX 1=R7; MARMUX 1=adder)
Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes
State_Dbg  out  5  current state encoding, debug only

Behaviour:
- Moore outputs decoded from the current state only. Every state not listed below drives all loads/gates/selects at 0 and Mem_OE=Mem_WE=1. These are also the values while in Halted after reset.
- Halted: stay while Run=0. Run=1 → S18.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC → S33.
- S33 (read): Mem_OE=0, MIO_EN=1, LD_MDR=1 for MEM_CYCLES consecutive cycles (wait counter cleared on entry) → S35.
- S35: GateMDR, LD_IR → S32.
- S32: LD_BEN. Next state by Opcode:
  - 0001 → S01, 0101 → S05, 1001 → S09, 0000 → S00
  - 1100 → S12, 0100 → S04, 0110 → S06, 0111 → S07, 1101 → P1
  - any other opcode → S18 (NOP, no architectural change)
- S01/S05: SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC, DRMUX=0, SR1MUX=0 → S18.
- S09: ALUK=10, GateALU, LD_REG, LD_CC → S18.
- S00: BEN=1 → S22, else → S18.
- S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC → S18.
- S12: SR1MUX=0, ALUK=11, GateALU, PCMUX=01, LD_PC → S18.
- S04: GatePC, DRMUX=1, LD_REG → S21.
- S21: IR_11=1 → ADDR1MUX=0, ADDR2MUX=11; IR_11=0 → ADDR1MUX=1, ADDR2MUX=00. PCMUX=10, LD_PC → S18.
- S06/S07: ADDR1MUX=1, ADDR2MUX=01, MARMUX=1, GateMARMUX, LD_MAR → S25 / S23.
- S25: same as S33 → S27.
- S27: GateMDR, LD_REG, LD_CC, DRMUX=0 → S18.
- S23: SR1MUX=1, ALUK=11, GateALU, MIO_EN=0, LD_MDR → S16.
- S16: Mem_WE=0 for MEM_CYCLES cycles → S18.
- P1: LD_LED on the entry cycle only. Stay while Continue=0; Continue=1 → P2.
- P2: stay while Continue=1; Continue=0 → S18. A held Continue therefore advances exactly one instruction.
- Never more than one Gate* high. LD_REG/LD_PC never high in Halted.
- Reset has priority over all transitions, including mid memory-wait (strobes deassert next cycle) and while paused. The wait counter clears on reset.
- Run is sampled only in Halted. Run deasserting mid-program does not halt execution.

Test Plan:
- Reset=1 for 2 cycles, Run=0 → Halted, all loads 0, Mem_OE=Mem_WE=1; Run=1 → S18 (GatePC, LD_MAR, LD_PC), then Mem_OE=0 for exactly 3 cycles, then S35, S32.
- Opcode=0001, IR_5=1 → S01 drives SR2MUX=1, ALUK=00, GateALU, LD_REG, LD_CC in one cycle; next state S18; full instruction takes 1+3+1+1+1=7 cycles.
- Opcode=0000 with BEN=0 → S00→S18 with no LD_PC; with BEN=1 → S22 asserts PCMUX=10, ADDR2MUX=10, LD_PC.
- Opcode=0111 (STR) → S07 (GateMARMUX, LD_MAR), S23 (MIO_EN=0, LD_MDR, ALUK=11), then Mem_WE=0 for 3 cycles, then S18.
- Opcode=1101, Continue=0 → LD_LED pulses 1 cycle, FSM holds P1 for 10 cycles; Continue=1 → P2 held; Continue=0 → S18.
- Reset asserted during 2nd cycle of S33 → next cycle Halted, Mem_OE=1; Opcode=1111 → S32→S18 with no LD_REG/LD_PC.
